// File: rtl/led_mode_ctrl_pkg.sv
// Shared types and constants for the LED mode controller and the pattern selector.
package led_mode_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CHK_PRESS = 2'd1,
      HELD      = 2'd2,
      CHK_REL   = 2'd3
   } deb_state_e;

   localparam logic [1:0] MODE_SHIFT_A = 2'b00;
   localparam logic [1:0] MODE_SHIFT_B = 2'b01;
   localparam logic [1:0] MODE_FILL    = 2'b10;
   localparam logic [1:0] MODE_RSVD    = 2'b11;

   // Reserved code is still part of the cycle so S simply counts modulo 4.
   function automatic logic [1:0] next_mode(input logic [1:0] m);
      case (m)
         MODE_SHIFT_A: return MODE_SHIFT_B;
         MODE_SHIFT_B: return MODE_FILL;
         MODE_FILL:    return MODE_RSVD;
         MODE_RSVD:    return MODE_SHIFT_A;
         default:      return MODE_SHIFT_A;
      endcase
   endfunction

endpackage

// File: rtl/led_mode_ctrl_btn_debounce.sv
// Button synchroniser and press/release debounce FSM; emits one press pulse per clean press.
// With AUTO_CYCLE_EN defined an idle indication is also exported.
module led_mode_ctrl_btn_debounce
   import led_mode_ctrl_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
`ifdef AUTO_CYCLE_EN
   output logic idle,
`endif
   output logic press
);

   localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

   logic          sync1_q;
   logic          btn_s_q;
   deb_state_e    state_q, state_d;
   logic [DW-1:0] deb_cnt_q, deb_cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= 1'b0;
         btn_s_q   <= 1'b0;
         state_q   <= IDLE;
         deb_cnt_q <= '0;
      end else begin
         sync1_q   <= btn;
         btn_s_q   <= sync1_q;
         state_q   <= state_d;
         deb_cnt_q <= deb_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      deb_cnt_d = deb_cnt_q;
      press     = 1'b0;
      case (state_q)
         IDLE: begin
            deb_cnt_d = '0;
            if (btn_s_q) state_d = CHK_PRESS;
         end
         CHK_PRESS: begin
            if (!btn_s_q) begin
               state_d   = IDLE;
               deb_cnt_d = '0;
            end else if (deb_cnt_q == DEB_LAST) begin
               press     = 1'b1;
               state_d   = HELD;
               deb_cnt_d = '0;
            end else begin
               deb_cnt_d = deb_cnt_q + 1'b1;
            end
         end
         HELD: begin
            deb_cnt_d = '0;
            if (!btn_s_q) state_d = CHK_REL;
         end
         CHK_REL: begin
            if (btn_s_q) begin
               state_d   = HELD;
               deb_cnt_d = '0;
            end else if (deb_cnt_q == DEB_LAST) begin
               state_d   = IDLE;
               deb_cnt_d = '0;
            end else begin
               deb_cnt_d = deb_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d   = IDLE;
            deb_cnt_d = '0;
         end
      endcase
   end

`ifdef AUTO_CYCLE_EN
   assign idle = (state_q == IDLE);
`endif

endmodule

// File: rtl/led_mode_ctrl.sv
// LED mode controller: debounced button steps the 2-bit select code S; slow tick divider restarts on every mode change.
// Define AUTO_CYCLE_EN to also advance S automatically after AUTO_TICKS idle ticks.
module led_mode_ctrl
   import led_mode_ctrl_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = 500000,
   parameter int unsigned TICK_DIV   = 12500000,
   parameter int unsigned AUTO_TICKS = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn,
   output logic [1:0] S,
   output logic       tick,
   output logic       mode_chg
);

   localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   if (DEB_CYCLES < 2 || TICK_DIV < 2 || AUTO_TICKS < 1) begin : g_bad_param
      $error("led_mode_ctrl: DEB_CYCLES and TICK_DIV must be >= 2, AUTO_TICKS >= 1");
   end

   logic          press;
   logic          advance;
   logic [1:0]    s_q, s_d;
   logic          mode_chg_q, mode_chg_d;
   logic          tick_q, tick_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;

`ifdef AUTO_CYCLE_EN
   localparam int unsigned IW = $clog2(AUTO_TICKS + 1);
   localparam logic [IW-1:0] IDLE_LAST = IW'(AUTO_TICKS - 1);

   logic          idle;
   logic          auto_adv;
   logic [IW-1:0] idle_cnt_q, idle_cnt_d;

   led_mode_ctrl_btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
   ) u_btn_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn),
      .idle (idle),
      .press(press)
   );

   // The tick that completes the idle count triggers the advance on the following edge.
   assign auto_adv = idle && tick_q && (idle_cnt_q == IDLE_LAST);
   assign advance  = press | auto_adv;

   always_comb begin
      idle_cnt_d = idle_cnt_q;
      if (advance || !idle) idle_cnt_d = '0;
      else if (tick_q)      idle_cnt_d = idle_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) idle_cnt_q <= '0;
      else        idle_cnt_q <= idle_cnt_d;
   end
`else
   led_mode_ctrl_btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
   ) u_btn_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn),
      .press(press)
   );

   assign advance = press;
`endif

   // A mode change wins over a terminal count: the tick is dropped and the divider restarts.
   always_comb begin
      s_d        = s_q;
      mode_chg_d = advance;
      tick_d     = 1'b0;
      tick_cnt_d = tick_cnt_q + 1'b1;
      if (advance) begin
         s_d        = next_mode(s_q);
         tick_cnt_d = '0;
      end else if (tick_cnt_q == TICK_LAST) begin
         tick_d     = 1'b1;
         tick_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q        <= MODE_SHIFT_A;
         mode_chg_q <= 1'b0;
         tick_q     <= 1'b0;
         tick_cnt_q <= '0;
      end else begin
         s_q        <= s_d;
         mode_chg_q <= mode_chg_d;
         tick_q     <= tick_d;
         tick_cnt_q <= tick_cnt_d;
      end
   end

   assign S        = s_q;
   assign tick     = tick_q;
   assign mode_chg = mode_chg_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed self-checking bench for led_mode_ctrl with DEB_CYCLES=4, TICK_DIV=5, AUTO_TICKS=3.
module tb_led_mode_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn;
   logic [1:0] S;
   logic       tick;
   logic       mode_chg;

   int vectors     = 0;
   int miscompares = 0;
   int pulses      = 0;

   always #5 clk = ~clk;

   led_mode_ctrl #(
      .DEB_CYCLES(4),
      .TICK_DIV  (5),
      .AUTO_TICKS(3)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn     (btn),
      .S       (S),
      .tick    (tick),
      .mode_chg(mode_chg)
   );

   task automatic step();
      @(posedge clk);
      #1;
      if (mode_chg === 1'b1) pulses++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic press_btn(input int hi, input int lo);
      btn = 1'b1;
      run(hi);
      btn = 1'b0;
      run(lo);
   endtask

   // Leaves the bench at posedge+1 with reset just released; the next edge is edge 1.
   task automatic do_reset();
      step();
      btn   = 1'b0;
      rst_n = 1'b0;
      run(3);
      rst_n = 1'b1;
      pulses = 0;
   endtask

   task automatic test_reset();
      do_reset();
      press_btn(10, 10);
      btn = 1'b1;
      run(4);
      rst_n = 1'b0;
      #1;
      vectors++;
      if (S !== 2'b00) begin
         miscompares++; $display("FAIL reset_S: got %b expected 00", S);
      end
      vectors++;
      if (tick !== 1'b0) begin
         miscompares++; $display("FAIL reset_tick: got %b expected 0", tick);
      end
      vectors++;
      if (mode_chg !== 1'b0) begin
         miscompares++; $display("FAIL reset_mode_chg: got %b expected 0", mode_chg);
      end
      run(2);
      rst_n = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         step();
         vectors++;
         if (mode_chg !== (i == 7)) begin
            miscompares++;
            $display("FAIL post_reset_press cycle %0d: mode_chg got %b expected %b", i, mode_chg, (i == 7));
         end
      end
      vectors++;
      if (S !== 2'b01) begin
         miscompares++; $display("FAIL post_reset_S: got %b expected 01", S);
      end
      btn = 1'b0;
      run(10);
   endtask

   task automatic test_clean_press();
      int first;
      do_reset();
      first = -1;
      btn = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         step();
         if (mode_chg === 1'b1 && first < 0) first = i;
      end
      btn = 1'b0;
      run(10);
      vectors++;
      if (first != 7) begin
         miscompares++; $display("FAIL clean_latency: got %0d expected 7", first);
      end
      vectors++;
      if (pulses != 1) begin
         miscompares++; $display("FAIL clean_pulses: got %0d expected 1", pulses);
      end
      vectors++;
      if (S !== 2'b01) begin
         miscompares++; $display("FAIL clean_S: got %b expected 01", S);
      end
   endtask

   task automatic test_bounce();
      do_reset();
      press_btn(3, 1);
      press_btn(3, 12);
      vectors++;
      if (pulses != 0) begin
         miscompares++; $display("FAIL bounce_pulses: got %0d expected 0", pulses);
      end
      vectors++;
      if (S !== 2'b00) begin
         miscompares++; $display("FAIL bounce_S: got %b expected 00", S);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] seq [4];
      seq = '{2'b01, 2'b10, 2'b11, 2'b00};
      do_reset();
      for (int k = 0; k < 4; k++) begin
         pulses = 0;
         press_btn(10, 10);
         vectors++;
         if (pulses != 1) begin
            miscompares++; $display("FAIL seq_pulses[%0d]: got %0d expected 1", k, pulses);
         end
         vectors++;
         if (S !== seq[k]) begin
            miscompares++; $display("FAIL seq_S[%0d]: got %b expected %b", k, S, seq[k]);
         end
      end
      pulses = 0;
      press_btn(50, 10);
      vectors++;
      if (pulses != 1) begin
         miscompares++; $display("FAIL hold_pulses: got %0d expected 1", pulses);
      end
      vectors++;
      if (S !== 2'b01) begin
         miscompares++; $display("FAIL hold_S: got %b expected 01", S);
      end
   endtask

   task automatic test_tick_spacing();
      do_reset();
      for (int i = 1; i <= 15; i++) begin
         step();
         vectors++;
         if (tick !== (i % 5 == 0)) begin
            miscompares++;
            $display("FAIL tick_free cycle %0d: got %b expected %b", i, tick, (i % 5 == 0));
         end
      end
   endtask

   task automatic test_tick_collision();
      do_reset();
      run(3);
      btn = 1'b1;
      for (int i = 4; i <= 16; i++) begin
         step();
         vectors++;
         if (tick !== (i == 5 || i == 15)) begin
            miscompares++;
            $display("FAIL tick_collide cycle %0d: got %b expected %b", i, tick, (i == 5 || i == 15));
         end
         vectors++;
         if (mode_chg !== (i == 10)) begin
            miscompares++;
            $display("FAIL chg_collide cycle %0d: got %b expected %b", i, mode_chg, (i == 10));
         end
      end
      btn = 1'b0;
      run(10);
   endtask

`ifdef AUTO_CYCLE_EN
   task automatic test_auto_cycle();
      logic [1:0] exp_s;
      do_reset();
      for (int i = 1; i <= 50; i++) begin
         step();
         exp_s = 2'((i / 16) % 4);
         vectors++;
         if (mode_chg !== (i % 16 == 0)) begin
            miscompares++;
            $display("FAIL auto_chg cycle %0d: got %b expected %b", i, mode_chg, (i % 16 == 0));
         end
         vectors++;
         if (S !== exp_s) begin
            miscompares++; $display("FAIL auto_S cycle %0d: got %b expected %b", i, S, exp_s);
         end
      end
   endtask
`else
   task automatic test_auto_cycle();
      do_reset();
      run(100);
      vectors++;
      if (pulses != 0) begin
         miscompares++; $display("FAIL noauto_pulses: got %0d expected 0", pulses);
      end
      vectors++;
      if (S !== 2'b00) begin
         miscompares++; $display("FAIL noauto_S: got %b expected 00", S);
      end
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      btn   = 1'b0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_back_to_back();
      test_tick_spacing();
      test_tick_collision();
      test_auto_cycle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
